// File: rtl/miner_nonce_dispatch_if.sv
// Host-side bundle for miner_nonce_dispatch: issue control, hasher nonce/result
// traffic and the golden-nonce readout. master = host/hasher side, slave = dispatcher.
interface miner_nonce_dispatch_if #(
  parameter int LOOP_LOG2 = 1,
  parameter int NUM_LANES = 2
);
  localparam int CW = (LOOP_LOG2 > 0) ? LOOP_LOG2 : 1;

  logic                      start;
  logic                      halt;
  logic [31:0]               nonce_base;
  logic [32*NUM_LANES-1:0]   nonce_out;
  logic                      nonce_valid;
  logic [CW-1:0]             cnt_out;
  logic                      feedback;
  logic                      hash_valid;
  logic [32*NUM_LANES-1:0]   hash_h7;
  logic [31:0]               gn_data;
  logic                      gn_valid;
  logic                      gn_ready;
  logic [7:0]                gn_dropped;
  logic                      tag_error;
  logic                      exhausted;
  logic                      busy;

  modport master (
    output start, halt, nonce_base, hash_valid, hash_h7, gn_ready,
    input  nonce_out, nonce_valid, cnt_out, feedback, gn_data, gn_valid,
           gn_dropped, tag_error, exhausted, busy
  );

  modport slave (
    input  start, halt, nonce_base, hash_valid, hash_h7, gn_ready,
    output nonce_out, nonce_valid, cnt_out, feedback, gn_data, gn_valid,
           gn_dropped, tag_error, exhausted, busy
  );
endinterface

// File: rtl/miner_nonce_dispatch.sv
// Nonce batch dispatcher with in-order batch tagging and golden-nonce FIFO.
// Optional MINER_HASH_COUNT_EN adds a 48-bit count of lane hashes checked.
module miner_nonce_dispatch #(
  parameter int          LOOP_LOG2      = 1,
  parameter int          NUM_LANES      = 2,
  parameter int          TAG_DEPTH_LOG2 = 3,
  parameter int          GN_DEPTH_LOG2  = 2,
  parameter logic [31:0] GOLDEN_H7      = 32'ha41f32e7
) (
  input  logic                  hash_clk,
  input  logic                  reset,
`ifdef MINER_HASH_COUNT_EN
  output logic [47:0]           hash_count,
`endif
  miner_nonce_dispatch_if.slave bus
);
  localparam int CW = (LOOP_LOG2 > 0) ? LOOP_LOG2 : 1;
  localparam int TD = 1 << TAG_DEPTH_LOG2;
  localparam int GD = 1 << GN_DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]             cnt;
  logic [31:0]               base;
  logic [32:0]               base_sum;
  logic [32*NUM_LANES-1:0]   nonce_p1;
  logic                      vld_p1;
  logic [31:0]               tag_mem [TD];
  logic [TAG_DEPTH_LOG2:0]   tag_wr, tag_rd;
  logic [31:0]               gn_mem [GD];
  logic [GN_DEPTH_LOG2:0]    gn_wr, gn_rd;
  logic                      tag_err_r, exh_r;
  logic [7:0]                dropped;

  logic                      tag_empty, tag_full, gn_empty, gn_full;
  logic                      issue, pop, gn_push, gn_pop, any_match;
  logic [7:0]                n_match, drop_cnt;
  logic [31:0]               low_off, tag_head;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hff : s[7:0];
  endfunction

  assign tag_empty = (tag_wr == tag_rd);
  assign tag_full  = (tag_wr[TAG_DEPTH_LOG2] != tag_rd[TAG_DEPTH_LOG2]) &&
                     (tag_wr[TAG_DEPTH_LOG2-1:0] == tag_rd[TAG_DEPTH_LOG2-1:0]);
  assign gn_empty  = (gn_wr == gn_rd);
  assign gn_full   = (gn_wr[GN_DEPTH_LOG2] != gn_rd[GN_DEPTH_LOG2]) &&
                     (gn_wr[GN_DEPTH_LOG2-1:0] == gn_rd[GN_DEPTH_LOG2-1:0]);

  assign issue    = (state == RUN) && (cnt == '0) && !bus.halt && !tag_full;
  assign base_sum = {1'b0, base} + 33'(NUM_LANES);
  assign pop      = bus.hash_valid && !tag_empty;
  assign gn_pop   = !gn_empty && bus.gn_ready;
  assign tag_head = tag_mem[tag_rd[TAG_DEPTH_LOG2-1:0]];

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (issue && base_sum[32]) state_nxt = IDLE;
               else if (bus.halt && cnt == '0) state_nxt = PAUSE;
      PAUSE:   if (!bus.halt) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Result stage: lowest matching lane wins, every other match is a loss
  always_comb begin
    any_match = 1'b0;
    low_off   = '0;
    n_match   = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      if (bus.hash_h7[32*k +: 32] == GOLDEN_H7) begin
        any_match = 1'b1;
        low_off   = 32'(k);
        n_match   = n_match + 8'd1;
      end
    end
    drop_cnt = '0;
    if (pop && any_match) drop_cnt = n_match - 8'd1 + (gn_full ? 8'd1 : 8'd0);
    gn_push = pop && any_match && !gn_full;
  end

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      base      <= '0;
      nonce_p1  <= '0;
      vld_p1    <= 1'b0;
      tag_wr    <= '0;
      tag_rd    <= '0;
      gn_wr     <= '0;
      gn_rd     <= '0;
      tag_err_r <= 1'b0;
      exh_r     <= 1'b0;
      dropped   <= '0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= issue;
      if (state == IDLE && bus.start) base <= bus.nonce_base;
      else if (issue)                 base <= base_sum[31:0];
      if (LOOP_LOG2 == 0)             cnt <= '0;
      else if (issue || cnt != '0)    cnt <= cnt + CW'(1);
      if (issue) begin
        for (int k = 0; k < NUM_LANES; k++) nonce_p1[32*k +: 32] <= base + 32'(k);
        tag_wr <= tag_wr + 1'b1;
      end
      if (issue && base_sum[32])         exh_r     <= 1'b1;
      if (pop)                           tag_rd    <= tag_rd + 1'b1;
      if (bus.hash_valid && tag_empty)   tag_err_r <= 1'b1;
      if (gn_push)                       gn_wr     <= gn_wr + 1'b1;
      if (gn_pop)                        gn_rd     <= gn_rd + 1'b1;
      dropped <= sat_add8(dropped, drop_cnt);
    end
  end

  always_ff @(posedge hash_clk) begin
    if (issue)   tag_mem[tag_wr[TAG_DEPTH_LOG2-1:0]] <= base;
    if (gn_push) gn_mem[gn_wr[GN_DEPTH_LOG2-1:0]]    <= tag_head + low_off;
  end

`ifdef MINER_HASH_COUNT_EN
  always_ff @(posedge hash_clk) begin
    if (reset)    hash_count <= '0;
    else if (pop) hash_count <= hash_count + 48'(NUM_LANES);
  end
`endif

  assign bus.nonce_out   = nonce_p1;
  assign bus.nonce_valid = vld_p1;
  assign bus.cnt_out     = cnt;
  assign bus.feedback    = (cnt != '0);
  assign bus.gn_valid    = !gn_empty;
  assign bus.gn_data     = gn_empty ? 32'h0 : gn_mem[gn_rd[GN_DEPTH_LOG2-1:0]];
  assign bus.gn_dropped  = dropped;
  assign bus.tag_error   = tag_err_r;
  assign bus.exhausted   = exh_r;
  assign bus.busy        = (state != IDLE) || !tag_empty;
endmodule
